// File: rtl/porta_ctrl_pkg.sv
// Shared constants for the ColecoVision controller-port / Z80 bus-assist block.
package porta_ctrl_pkg;

  localparam logic [1:0] DEC_FIRE = 2'b00;
  localparam logic [1:0] DEC_ARM  = 2'b10;
  localparam logic [1:0] DEC_READ = 2'b11;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Bit positions of debounced controller lines within the read byte
  localparam int unsigned D_DB0  = 0;
  localparam int unsigned D_DB3  = 1;
  localparam int unsigned D_DB1  = 2;
  localparam int unsigned D_DB2  = 3;
  localparam int unsigned D_ONE  = 4;
  localparam int unsigned D_DB4  = 5;
  localparam int unsigned D_DB5  = 6;
  localparam int unsigned D_ZERO = 7;

  localparam logic [7:0] D_IDLE = 8'hFF;

  function automatic logic [7:0] map_d(input logic [5:0] db);
    logic [7:0] d;
    d         = D_IDLE;
    d[D_DB0]  = db[0];
    d[D_DB1]  = db[1];
    d[D_DB2]  = db[2];
    d[D_DB3]  = db[3];
    d[D_DB4]  = db[4];
    d[D_DB5]  = db[5];
    d[D_ONE]  = 1'b1;
    d[D_ZERO] = 1'b0;
    return d;
  endfunction

endpackage

// File: rtl/porta_debounce.sv
// One controller line: 2-flop synchroniser followed by a stable-count debouncer.
module porta_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 8
) (
  input  logic clk,
  input  logic rstn,
  input  logic din,
  output logic dout
);

  localparam int unsigned CW = 8;
  localparam logic [CW-1:0] LIMIT = CW'(DEBOUNCE_CYCLES);

  logic          s1;
  logic          s2;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s1 <= 1'b1;
      s2 <= 1'b1;
    end else begin
      s1 <= din;
      s2 <= s1;
    end
  end

  // Counter runs only while the synchronised input disagrees; it saturates.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt  <= '0;
      dout <= 1'b1;
    end else if (s2 == dout) begin
      cnt <= '0;
    end else if (cnt >= LIMIT) begin
      dout <= s2;
      cnt  <= '0;
    end else if (cnt != '1) begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/porta_ctrl_bus.sv
// Controller select latch, controller read port and M1 wait-state generator.
module porta_ctrl_bus
  import porta_ctrl_pkg::*;
#(
  parameter int unsigned NUM_PLAYERS     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 8,
  parameter int unsigned WAIT_CYCLES     = 1
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic [7:0]                 A,
  input  logic                       IORQn,
  input  logic                       RDn,
  input  logic                       WRn,
  input  logic                       M1n,
  input  logic [6*NUM_PLAYERS-1:0]   C_IN,
  output logic [NUM_PLAYERS-1:0]     C_PIN4,
  output logic [NUM_PLAYERS-1:0]     C_PIN7,
  output logic [7:0]                 D_OUT,
  output logic                       D_OE,
  output logic                       WAIT_DRV
);

  localparam int unsigned NB  = 6 * NUM_PLAYERS;
  localparam int unsigned PW  = (NUM_PLAYERS > 2) ? $clog2(NUM_PLAYERS) : 1;
  localparam int unsigned WCW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES + 1) : 1;
  localparam logic [WCW-1:0] WLIM = WCW'(WAIT_CYCLES);

  logic [2:0]     sync1;
  logic [2:0]     sync2;
  logic           iorq_s;
  logic           wr_s;
  logic           m1_s;
  logic           fire;
  logic           arm;
  logic           pin4;
  logic           pin7;
  logic [NB-1:0]  db;
  logic [PW-1:0]  idx;
  logic [7:0]     rd_sel;
  logic [1:0]     state;
  logic [1:0]     state_nxt;
  logic [WCW-1:0] wcnt;
  logic [WCW-1:0] wcnt_nxt;
  logic           unused_a;

  assign unused_a = ^A[4:0];

  // Strobe synchronisers, order {IORQn, WRn, M1n}
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync1 <= 3'b111;
      sync2 <= 3'b111;
    end else begin
      sync1 <= {IORQn, WRn, M1n};
      sync2 <= sync1;
    end
  end

  assign {iorq_s, wr_s, m1_s} = sync2;

  assign fire = A[7] & ~iorq_s & ~wr_s & (A[6:5] == DEC_FIRE);
  assign arm  = A[7] & ~iorq_s & ~wr_s & (A[6:5] == DEC_ARM);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pin4 <= 1'b1;
      pin7 <= 1'b0;
    end else if (fire) begin
      pin4 <= 1'b0;
      pin7 <= 1'b1;
    end else if (arm) begin
      pin4 <= 1'b1;
      pin7 <= 1'b0;
    end
  end

  assign C_PIN4 = {NUM_PLAYERS{pin4}};
  assign C_PIN7 = {NUM_PLAYERS{pin7}};

  for (genvar i = 0; i < NB; i++) begin : g_db
    porta_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db (
      .clk  (clk),
      .rstn (rstn),
      .din  (C_IN[i]),
      .dout (db[i])
    );
  end

  // Read path is purely combinational from the raw bus strobes.
  always_comb begin
    idx    = (NUM_PLAYERS == 1) ? '0 : A[PW:1];
    D_OE   = A[7] & ~IORQn & ~RDn & (A[6:5] == DEC_READ);
    rd_sel = D_IDLE;
    for (int p = 0; p < NUM_PLAYERS; p++) begin
      if (32'(idx) == 32'(p)) rd_sel = map_d(db[6*p +: 6]);
    end
    D_OUT = D_OE ? rd_sel : D_IDLE;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= ST_IDLE;
      wcnt     <= '0;
      WAIT_DRV <= 1'b0;
    end else begin
      state    <= state_nxt;
      wcnt     <= wcnt_nxt;
      WAIT_DRV <= (state_nxt == ST_WAIT);
    end
  end

  // One burst per M1 low period; M1 rising mid-burst aborts it.
  always_comb begin
    state_nxt = state;
    wcnt_nxt  = wcnt;
    case (state)
      ST_IDLE: begin
        if (!m1_s) begin
          if (WAIT_CYCLES > 0) begin
            state_nxt = ST_WAIT;
            wcnt_nxt  = WCW'(1);
          end else begin
            state_nxt = ST_DONE;
          end
        end
      end
      ST_WAIT: begin
        if (m1_s) begin
          state_nxt = ST_IDLE;
          wcnt_nxt  = '0;
        end else if (wcnt >= WLIM) begin
          state_nxt = ST_DONE;
          wcnt_nxt  = '0;
        end else begin
          wcnt_nxt = wcnt + WCW'(1);
        end
      end
      ST_DONE: begin
        if (m1_s) state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
        wcnt_nxt  = '0;
      end
    endcase
  end

endmodule
